// File: rtl/dbus_arbiter.sv
// rtl/dbus_arbiter.sv - MMIO/debugger arbiter sharing one external data bus
// Core MMIO loads/stores and debugger accesses are serialised with round-robin tie-break and a wait timeout.
module dbus_arbiter #(
    parameter logic [63:0] MMIO_BASE = 64'hFFFF_FFFF_0000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  i_mem_load_type,
    input  logic [1:0]  i_mem_store_type,
    input  logic [63:0] i_mem_addr,
    input  logic [63:0] i_mem_wdata,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_d_valid,
    output logic        o_d_ready,
    output logic [63:0] o_d_rdata,
    output logic        o_bus_error,
    input  logic        i_dbg_req,
    input  logic        i_dbg_we,
    input  logic [63:0] i_dbg_addr,
    input  logic [63:0] i_dbg_wdata,
    output logic        o_dbg_ack,
    output logic [63:0] o_dbg_rdata,
    output logic        o_dbg_err,
    output logic        o_bus_req_valid,
    input  logic        i_bus_req_ready,
    output logic        o_bus_we,
    output logic [1:0]  o_bus_size,
    output logic [63:0] o_bus_addr,
    output logic [63:0] o_bus_wdata,
    input  logic        i_bus_resp_valid,
    input  logic [63:0] i_bus_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_C_REQ  = 3'd1;
    localparam logic [2:0] S_C_RESP = 3'd2;
    localparam logic [2:0] S_C_DONE = 3'd3;
    localparam logic [2:0] S_D_REQ  = 3'd4;
    localparam logic [2:0] S_D_RESP = 3'd5;
    localparam logic [2:0] S_D_DONE = 3'd6;

    localparam int            CW        = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_wait;
    logic          r_last_dbg;
    logic          r_squashed;
    logic          r_bus_we;
    logic [1:0]    r_bus_size;
    logic [63:0]   r_bus_addr;
    logic [63:0]   r_bus_wdata;
    logic          r_d_valid;
    logic          r_d_ready;
    logic [63:0]   r_d_rdata;
    logic          r_bus_error;
    logic          r_dbg_ack;
    logic [63:0]   r_dbg_rdata;
    logic          r_dbg_err;

    logic w_core_access;
    logic w_core_store;
    logic w_core_mmio;
    logic w_core_grant;
    logic w_wait_expired;
    logic w_squash;

    assign w_core_access  = (i_mem_load_type != 2'b00) || (i_mem_store_type != 2'b00);
    assign w_core_store   = (i_mem_store_type != 2'b00);
    assign w_core_mmio    = w_core_access && (i_mem_addr >= MMIO_BASE) && !i_flush;
    // On a tie the requester that did not win last time gets the bus.
    assign w_core_grant   = w_core_mmio && (!i_dbg_req || r_last_dbg);
    assign w_wait_expired = (r_wait == WAIT_LAST);
    assign w_squash       = r_squashed || i_flush;

    assign o_stall         = w_core_mmio && (r_state != S_C_DONE);
    assign o_bus_req_valid = (r_state == S_C_REQ) || (r_state == S_D_REQ);
    assign o_bus_we        = r_bus_we;
    assign o_bus_size      = r_bus_size;
    assign o_bus_addr      = r_bus_addr;
    assign o_bus_wdata     = r_bus_wdata;
    assign o_d_valid       = r_d_valid;
    assign o_d_ready       = r_d_ready;
    assign o_d_rdata       = r_d_rdata;
    assign o_bus_error     = r_bus_error;
    assign o_dbg_ack       = r_dbg_ack;
    assign o_dbg_rdata     = r_dbg_rdata;
    assign o_dbg_err       = r_dbg_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_last_dbg  <= 1'b1;
            r_squashed  <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_size  <= 2'b00;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_d_valid   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= '0;
            r_bus_error <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
            r_dbg_err   <= 1'b0;
        end else begin
            r_d_valid   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_bus_error <= 1'b0;
            r_dbg_ack   <= 1'b0;
            r_dbg_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wait     <= '0;
                    r_squashed <= 1'b0;
                    if (w_core_grant) begin
                        r_state     <= S_C_REQ;
                        r_last_dbg  <= 1'b0;
                        r_bus_we    <= w_core_store;
                        r_bus_size  <= w_core_store ? i_mem_store_type : i_mem_load_type;
                        r_bus_addr  <= i_mem_addr;
                        r_bus_wdata <= i_mem_wdata;
                    end else if (i_dbg_req) begin
                        r_state     <= S_D_REQ;
                        r_last_dbg  <= 1'b1;
                        r_bus_we    <= i_dbg_we;
                        r_bus_size  <= 2'b11;
                        r_bus_addr  <= i_dbg_addr;
                        r_bus_wdata <= i_dbg_wdata;
                    end
                end
                S_C_REQ: begin
                    // An accepted request is already on the bus, so a same-cycle flush only squashes it.
                    if (i_bus_req_ready) begin
                        r_state    <= S_C_RESP;
                        r_wait     <= '0;
                        r_squashed <= i_flush;
                    end else if (i_flush) begin
                        r_state <= S_IDLE;
                        r_wait  <= '0;
                    end else if (w_wait_expired) begin
                        r_state     <= S_C_DONE;
                        r_d_rdata   <= '1;
                        r_d_valid   <= !r_bus_we;
                        r_d_ready   <= r_bus_we;
                        r_bus_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_C_RESP: begin
                    if (i_bus_resp_valid || w_wait_expired) begin
                        r_state   <= S_C_DONE;
                        r_d_rdata <= i_bus_resp_valid ? i_bus_rdata : '1;
                        if (!w_squash) begin
                            r_d_valid   <= !r_bus_we;
                            r_d_ready   <= r_bus_we;
                            r_bus_error <= !i_bus_resp_valid;
                        end
                    end else begin
                        r_wait <= r_wait + CW'(1);
                        if (i_flush) begin
                            r_squashed <= 1'b1;
                        end
                    end
                end
                S_C_DONE: begin
                    r_state <= S_IDLE;
                end
                S_D_REQ: begin
                    if (i_bus_req_ready) begin
                        r_state <= S_D_RESP;
                        r_wait  <= '0;
                    end else if (w_wait_expired) begin
                        r_state     <= S_D_DONE;
                        r_dbg_rdata <= '1;
                        r_dbg_ack   <= 1'b1;
                        r_dbg_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_D_RESP: begin
                    if (i_bus_resp_valid || w_wait_expired) begin
                        r_state     <= S_D_DONE;
                        r_dbg_rdata <= i_bus_resp_valid ? i_bus_rdata : '1;
                        r_dbg_ack   <= 1'b1;
                        r_dbg_err   <= !i_bus_resp_valid;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_D_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
